// File: rtl/vx_interp_pkg.sv
// vx_interp_pkg: shared select codes, CSR field widths and fixed-point helpers
package vx_interp_pkg;

    localparam int INTERP_SEL_W = 2;
    localparam logic [INTERP_SEL_W-1:0] INTERP_SEL_A = 2'd0;
    localparam logic [INTERP_SEL_W-1:0] INTERP_SEL_B = 2'd1;
    localparam logic [INTERP_SEL_W-1:0] INTERP_SEL_C = 2'd2;

    // Round half up, arithmetic shift by frac, clamp to a dw-bit signed range.
    // Operands are carried in 128 bits so any unit with dw <= 63 can share it.
    function automatic logic signed [63:0] sat_round_shift(
        input logic signed [127:0] v,
        input int frac,
        input int dw
    );
        logic signed [127:0] r, hi, lo;
        r  = (v + (128'sd1 <<< (frac - 1))) >>> frac;
        hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (dw - 1));
        return (r > hi) ? hi[63:0] : ((r < lo) ? lo[63:0] : r[63:0]);
    endfunction

endpackage

// File: rtl/vx_interp_pipe_if.sv
// vx_interp_pipe_if: request/response handshake bundle of the plane interpolator
interface vx_interp_pipe_if #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_ATTRS  = 4,
    parameter int TAG_WIDTH  = 16
);
    localparam int ATTR_W = $clog2(NUM_ATTRS);

    logic                            req_valid;
    logic                            req_ready;
    logic [ATTR_W-1:0]               req_attr;
    logic [NUM_LANES-1:0]            req_mask;
    logic [NUM_LANES*DATA_WIDTH-1:0] req_x;
    logic [NUM_LANES*DATA_WIDTH-1:0] req_y;
    logic [TAG_WIDTH-1:0]            req_tag;
    logic                            rsp_valid;
    logic                            rsp_ready;
    logic [NUM_LANES-1:0]            rsp_mask;
    logic [NUM_LANES*DATA_WIDTH-1:0] rsp_data;
    logic [TAG_WIDTH-1:0]            rsp_tag;

    modport master (
        output req_valid, req_attr, req_mask, req_x, req_y, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_mask, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_attr, req_mask, req_x, req_y, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_mask, rsp_data, rsp_tag
    );

endinterface

// File: rtl/vx_interp_lane.sv
// vx_interp_lane: one lane's product stage and sum/round/saturate stage
module vx_interp_lane
    import vx_interp_pkg::*;
#(
    parameter int DW = 32,
    parameter int FB = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_i,
    input  logic                 act_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    input  logic signed [DW-1:0] c_i,
    input  logic signed [DW-1:0] x_i,
    input  logic signed [DW-1:0] y_i,
    output logic [DW-1:0]        res_o
);
    localparam int PW = 2 * DW;
    localparam int SW = 2 * DW + 2;

    logic signed [PW-1:0] pa_q, pb_q;
    logic signed [DW-1:0] c_q;
    logic                 act_q;
    logic signed [SW-1:0] sum;
    logic [DW-1:0]        res_d, res_q;

    // Inactive lanes keep their old products so the multipliers stay quiet
    always_ff @(posedge clk) begin
        if (reset) begin
            pa_q  <= '0;
            pb_q  <= '0;
            c_q   <= '0;
            act_q <= 1'b0;
        end else if (en_i) begin
            act_q <= act_i;
            if (act_i) begin
                pa_q <= PW'(a_i) * PW'(x_i);
                pb_q <= PW'(b_i) * PW'(y_i);
                c_q  <= c_i;
            end
        end
    end

    assign sum   = SW'(pa_q) + SW'(pb_q) + (SW'(c_q) <<< FB);
    assign res_d = act_q ? DW'(sat_round_shift(128'(sum), FB, DW)) : '0;

    always_ff @(posedge clk) begin
        if (reset) res_q <= '0;
        else if (en_i) res_q <= res_d;
    end

    assign res_o = res_q;

endmodule

// File: rtl/vx_interp_pipe.sv
// vx_interp_pipe: 3-stage multi-lane a*x + b*y + c interpolator with a CSR
// coefficient bank and valid/ready handshakes on both sides.
module vx_interp_pipe
    import vx_interp_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int NUM_ATTRS  = 4,
    parameter int TAG_WIDTH  = 16,
    localparam int ATTR_W    = $clog2(NUM_ATTRS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           csr_wr_en_i,
    input  logic [ATTR_W+INTERP_SEL_W-1:0] csr_wr_addr_i,
    input  logic [DATA_WIDTH-1:0]          csr_wr_data_i,
    vx_interp_pipe_if.slave                bus
);
    localparam int DW = DATA_WIDTH;
    localparam int LW = NUM_LANES * DATA_WIDTH;

    logic [DW-1:0]           a_q [NUM_ATTRS];
    logic [DW-1:0]           b_q [NUM_ATTRS];
    logic [DW-1:0]           c_q [NUM_ATTRS];
    logic [INTERP_SEL_W-1:0] wr_sel;
    logic [ATTR_W-1:0]       wr_slot;
    logic                    adv;

    logic                 s1_vld_q, s2_vld_q, s3_vld_q;
    logic [TAG_WIDTH-1:0] s1_tag_q, s2_tag_q, s3_tag_q;
    logic [NUM_LANES-1:0] s1_mask_q, s2_mask_q, s3_mask_q;
    logic [LW-1:0]        s1_x_q, s1_y_q;
    logic [DW-1:0]        s1_a_q, s1_b_q, s1_c_q;
    logic [DW-1:0]        lane_res [NUM_LANES];

    assign wr_sel  = csr_wr_addr_i[INTERP_SEL_W-1:0];
    assign wr_slot = csr_wr_addr_i[INTERP_SEL_W +: ATTR_W];

    // Bank reads happen before this edge's write lands, so a same-slot
    // accept in the write cycle sees the old coefficient
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ATTRS; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else if (csr_wr_en_i) begin
            if (wr_sel == INTERP_SEL_A) a_q[wr_slot] <= csr_wr_data_i;
            if (wr_sel == INTERP_SEL_B) b_q[wr_slot] <= csr_wr_data_i;
            if (wr_sel == INTERP_SEL_C) c_q[wr_slot] <= csr_wr_data_i;
        end
    end

    assign adv           = !s3_vld_q || bus.rsp_ready;
    assign bus.req_ready = adv;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s3_vld_q  <= 1'b0;
            s1_tag_q  <= '0;
            s2_tag_q  <= '0;
            s3_tag_q  <= '0;
            s1_mask_q <= '0;
            s2_mask_q <= '0;
            s3_mask_q <= '0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_c_q    <= '0;
        end else if (adv) begin
            s1_vld_q <= bus.req_valid;
            if (bus.req_valid) begin
                s1_tag_q  <= bus.req_tag;
                s1_mask_q <= bus.req_mask;
                s1_x_q    <= bus.req_x;
                s1_y_q    <= bus.req_y;
                s1_a_q    <= a_q[bus.req_attr];
                s1_b_q    <= b_q[bus.req_attr];
                s1_c_q    <= c_q[bus.req_attr];
            end
            s2_vld_q  <= s1_vld_q;
            s2_tag_q  <= s1_tag_q;
            s2_mask_q <= s1_mask_q;
            s3_vld_q  <= s2_vld_q;
            s3_tag_q  <= s2_tag_q;
            s3_mask_q <= s2_mask_q;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        vx_interp_lane #(
            .DW(DW),
            .FB(FRAC_BITS)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .en_i (adv),
            .act_i(s1_vld_q && s1_mask_q[l]),
            .a_i  (s1_a_q),
            .b_i  (s1_b_q),
            .c_i  (s1_c_q),
            .x_i  (s1_x_q[l*DW +: DW]),
            .y_i  (s1_y_q[l*DW +: DW]),
            .res_o(lane_res[l])
        );
    end

    always_comb begin
        bus.rsp_data = '0;
        for (int i = 0; i < NUM_LANES; i++) bus.rsp_data[i*DW +: DW] = lane_res[i];
    end

    assign bus.rsp_valid = s3_vld_q;
    assign bus.rsp_tag   = s3_tag_q;
    assign bus.rsp_mask  = s3_mask_q;

endmodule

// File: tb/tb_vx_interp_pipe.sv
// tb_vx_interp_pipe: scoreboard bench for the plane interpolator
module tb_vx_interp_pipe;

    typedef struct packed {
        logic [15:0]  tag;
        logic [3:0]   mask;
        logic [127:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_wr_en;
    logic [3:0]  csr_wr_addr;
    logic [31:0] csr_wr_data;
    int          cyc = 0;
    int          bp_from = -1;
    int          bp_to = -2;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          saw_stall = 1'b0;
    exp_t        sbq[$];
    logic [31:0] sh [4][3];

    vx_interp_pipe_if #(.NUM_LANES(4), .DATA_WIDTH(32), .NUM_ATTRS(4), .TAG_WIDTH(16)) bus ();

    vx_interp_pipe #(
        .NUM_LANES (4),
        .DATA_WIDTH(32),
        .FRAC_BITS (16),
        .NUM_ATTRS (4),
        .TAG_WIDTH (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .csr_wr_en_i  (csr_wr_en),
        .csr_wr_addr_i(csr_wr_addr),
        .csr_wr_data_i(csr_wr_data),
        .bus          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, b, c, x, y);
        logic signed [127:0] s;
        s = 128'($signed(a)) * 128'($signed(x)) + 128'($signed(b)) * 128'($signed(y))
          + 128'($signed(c)) * 65536 + 32768;
        s = s >>> 16;
        if (s > 128'sd2147483647) return 32'h7fffffff;
        if (s < -128'sd2147483648) return 32'h80000000;
        return s[31:0];
    endfunction

    // Monitor: sees the values present just before the coming rising edge
    always @(negedge clk) begin : mon
        exp_t e;
        bit   hold;
        logic [147:0] prev;
        if (reset) begin
            sbq.delete();
            for (int s = 0; s < 4; s++) for (int k = 0; k < 3; k++) sh[s][k] = 32'h0;
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 160'(bus.rsp_valid), 160'(1));
                chk("hold_rsp", 160'({bus.rsp_tag, bus.rsp_mask, bus.rsp_data}), 160'(prev));
            end
            if (!bus.req_ready) saw_stall = 1'b1;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sbq.size() == 0) chk("unexpected_rsp", 160'(bus.rsp_tag), 160'(20'hfffff));
                else begin
                    e = sbq.pop_front();
                    chk("rsp_tag", 160'(bus.rsp_tag), 160'(e.tag));
                    chk("rsp_mask", 160'(bus.rsp_mask), 160'(e.mask));
                    chk("rsp_data", 160'(bus.rsp_data), 160'(e.data));
                end
            end
            hold = bus.rsp_valid && !bus.rsp_ready;
            prev = {bus.rsp_tag, bus.rsp_mask, bus.rsp_data};
            if (bus.req_valid && bus.req_ready) begin
                e.tag  = bus.req_tag;
                e.mask = bus.req_mask;
                for (int l = 0; l < 4; l++)
                    e.data[l*32 +: 32] = bus.req_mask[l] ?
                        model(sh[bus.req_attr][0], sh[bus.req_attr][1], sh[bus.req_attr][2],
                              bus.req_x[l*32 +: 32], bus.req_y[l*32 +: 32]) : 32'h0;
                sbq.push_back(e);
            end
            if (csr_wr_en && csr_wr_addr[1:0] != 2'd3) sh[csr_wr_addr[3:2]][csr_wr_addr[1:0]] = csr_wr_data;
        end
    end

    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_ready = !(cyc >= bp_from && cyc <= bp_to);
        end
    end

    task automatic csr_wr(input logic [1:0] slot, input logic [1:0] sel, input logic [31:0] d);
        csr_wr_en   = 1'b1;
        csr_wr_addr = {slot, sel};
        csr_wr_data = d;
        @(posedge clk);
        #1;
        csr_wr_en = 1'b0;
    endtask

    task automatic send(input logic [1:0] attr, input logic [3:0] mask, input logic [127:0] x,
                        input logic [127:0] y, input logic [15:0] tag);
        bit ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_attr  = attr;
        bus.req_mask  = mask;
        bus.req_x     = x;
        bus.req_y     = y;
        bus.req_tag   = tag;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.req_ready;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (!ok) chk("req_timeout", 160'(0), 160'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 160'(sbq.size()), 160'(0));
    endtask

    initial begin
        reset         = 1'b1;
        csr_wr_en     = 1'b0;
        csr_wr_addr   = '0;
        csr_wr_data   = '0;
        bus.req_valid = 1'b0;
        bus.req_attr  = '0;
        bus.req_mask  = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_tag   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 160'(bus.rsp_valid), 160'(0));
        chk("rst_data", 160'(bus.rsp_data), 160'(0));
        chk("rst_tag", 160'(bus.rsp_tag), 160'(0));
        chk("rst_mask", 160'(bus.rsp_mask), 160'(0));
        chk("rst_ready", 160'(bus.req_ready), 160'(1));
        @(posedge clk);
        #1;

        // Basic: 2*3 + 0.5*4 + 1 = 9, returned three cycles after accept
        csr_wr(2'd1, 2'd0, 32'h00020000);
        csr_wr(2'd1, 2'd1, 32'h00008000);
        csr_wr(2'd1, 2'd2, 32'h00010000);
        send(2'd1, 4'hf, {4{32'h00030000}}, {4{32'h00040000}}, 16'h1234);
        @(negedge clk);
        chk("lat_n1", 160'(bus.rsp_valid), 160'(0));
        @(negedge clk);
        chk("lat_n2", 160'(bus.rsp_valid), 160'(0));
        @(negedge clk);
        chk("lat_n3", 160'(bus.rsp_valid), 160'(1));
        chk("basic_data", 160'(bus.rsp_data), 160'({4{32'h00090000}}));
        chk("basic_tag", 160'(bus.rsp_tag), 160'(16'h1234));
        @(posedge clk);
        #1;

        // Signed, half-up rounding and both saturation limits on slot 0
        csr_wr(2'd0, 2'd0, 32'hffff0000);
        send(2'd0, 4'hf, {4{32'h00020000}}, 128'h0, 16'h0002);
        csr_wr(2'd0, 2'd0, 32'h00000001);
        send(2'd0, 4'hf, {4{32'h00008000}}, 128'h0, 16'h0003);
        csr_wr(2'd0, 2'd0, 32'h7fff0000);
        send(2'd0, 4'hf, {4{32'h00020000}}, 128'h0, 16'h0004);
        send(2'd0, 4'hf, {4{32'hfffe0000}}, 128'h0, 16'h0005);
        drain();

        // Back-to-back stream with a response stall window; mask 0x5
        bp_from = cyc + 4;
        bp_to   = cyc + 8;
        for (int t = 1; t <= 6; t++) begin
            logic [127:0] xv;
            for (int l = 0; l < 4; l++) xv[l*32 +: 32] = 32'((t + l) << 16);
            send(2'd1, 4'h5, xv, {4{32'(t << 12)}}, 16'(t));
        end
        drain();
        chk("stall_seen", 160'(saw_stall), 160'(1));
        bp_from = -1;
        bp_to   = -2;

        // Same-cycle write and accept on slot 2 uses the old coefficient
        csr_wr_en   = 1'b1;
        csr_wr_addr = {2'd2, 2'd0};
        csr_wr_data = 32'h00010000;
        send(2'd2, 4'hf, {4{32'h00010000}}, 128'h0, 16'h0020);
        csr_wr_en = 1'b0;
        send(2'd2, 4'hf, {4{32'h00010000}}, 128'h0, 16'h0021);
        csr_wr(2'd2, 2'd3, 32'hdead0000);
        send(2'd2, 4'hf, {4{32'h00010000}}, 128'h0, 16'h0022);
        drain();

        // Reset with three requests in flight and responses blocked
        bp_from = cyc;
        bp_to   = cyc + 100000;
        @(posedge clk);
        #1;
        for (int t = 0; t < 3; t++) send(2'd1, 4'hf, {4{32'h00030000}}, {4{32'h00040000}}, 16'(16'h0040 + t));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        bp_from = -1;
        bp_to   = -2;
        @(negedge clk);
        chk("midrst_valid", 160'(bus.rsp_valid), 160'(0));
        @(posedge clk);
        #1;
        send(2'd1, 4'hf, {4{32'h00030000}}, {4{32'h00040000}}, 16'h0050);
        repeat (6) @(posedge clk);
        #1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vx_interp_pipe.md
Name: vx_interp_pipe

Overview:
Multi-lane, pipelined plane-equation interpolator: per lane computes result = a*x + b*y + c in signed fixed point.
Coefficients are CSR-programmed and held in a bank of NUM_ATTRS attribute slots; each request selects one slot.
Valid/ready handshakes on request and response with full backpressure. Results return in order, with the issuing tag for writeback routing.
Sits beside the ALU/FPU in the execute stage and feeds the commit path.

Parameters:
NUM_LANES, 4, lanes (threads) per request
DATA_WIDTH, 32, operand/coefficient/result width, signed two's complement
FRAC_BITS, 16, fractional bits of the Q format (1 <= FRAC_BITS < DATA_WIDTH)
NUM_ATTRS, 4, coefficient slots (power of two, >= 2)
TAG_WIDTH, 16, opaque request tag (uuid/wid/rd/wb packed by caller)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
csr_wr_en  in  1  coefficient write strobe
csr_wr_addr  in  log2(NUM_ATTRS)+2  [1:0]=select (0=A, 1=B, 2=C, 3=ignored); upper bits=slot
csr_wr_data  in  DATA_WIDTH  coefficient value
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_attr  in  log2(NUM_ATTRS)  coefficient slot
req_mask  in  NUM_LANES  active lanes
req_x  in  NUM_LANES*DATA_WIDTH  per-lane x
req_y  in  NUM_LANES*DATA_WIDTH  per-lane y
req_tag  in  TAG_WIDTH  passthrough tag
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_mask  out  NUM_LANES  echoed mask
rsp_data  out  NUM_LANES*DATA_WIDTH  per-lane results
rsp_tag  out  TAG_WIDTH  echoed tag

Behaviour:
- Reset: all coefficients 0; all stage valids 0; rsp_valid=0, rsp_mask=0, rsp_data=0, rsp_tag=0. Reset mid-operation discards all in-flight requests; no response is emitted for them.
- Pipeline: 3 stages. S1 registers operands, tag and mask, plus A/B/C read from slot req_attr. S2 registers the products a*x and b*y at full 2*DATA_WIDTH width. S3 registers the sum, round, shift and saturate; S3 drives the rsp_* outputs.
- Latency: accept at cycle N gives rsp_valid at N+3 when there is no backpressure. Throughput is 1 request per cycle.
- Stall: advance = !rsp_valid | rsp_ready. All stages advance together when advance=1 and hold otherwise. req_ready = advance, combinational from rsp_valid and rsp_ready; it does not depend on req_valid. Bubbles propagate as valid=0 and are not compressed.
- rsp_* holds stable while rsp_valid & !rsp_ready.
- Arithmetic:
  - sum = a*x + b*y + (c << FRAC_BITS), in 2*DATA_WIDTH+2 bits.
  - Add 1 << (FRAC_BITS-1) for round-half-up.
  - Arithmetic shift right by FRAC_BITS.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Masked-off lanes output 0 and their multipliers are not required to toggle.
- CSR: a write takes effect the next cycle. A write and an accept in the same cycle to the same slot: the request uses the old value. select=3 is ignored. Writes during a stall are allowed and do not affect requests already in flight.

Decomposition:
- Package vx_interp_pkg holds:
  - select constants INTERP_SEL_A/B/C;
  - CSR address field widths;
  - a function for saturating round-shift, shared with future fixed-point units.
- Sub-module vx_interp_lane: one lane's S2/S3 datapath (multiply, sum, round, saturate). It takes a stage enable and is instantiated NUM_LANES times via generate. The top level owns the coefficient bank, valid/tag/mask pipeline and handshake.

Test Plan:
- Basic: slot1 A=0x00020000, B=0x00008000, C=0x00010000; x=0x00030000, y=0x00040000, mask=0xF, tag=0x1234 -> rsp at N+3, all lanes 0x00090000, tag 0x1234.
- Signed/rounding: A=0xFFFF0000, x=0x00020000, B=C=0 -> 0xFFFE0000. A=0x00000001, x=0x00008000 -> 0x00000001 (half rounds up).
- Saturation: A=0x7FFF0000, x=0x00020000 -> 0x7FFFFFFF. A=0x7FFF0000, x=0xFFFE0000 -> 0x80000000.
- Backpressure: stream 6 back-to-back requests with tags 1..6, rsp_ready=0 for cycles 4-8 -> req_ready drops, rsp held stable, all 6 tags delivered once, in order, with correct data. Mask 0x5 -> lanes 1 and 3 read 0.
- CSR hazard: write A=0x00010000 to slot 2 in the same cycle a slot-2 request (x=0x00010000) is accepted with old A=0 -> result 0. The next request gives 0x00010000. A write with select=3 leaves A/B/C unchanged.
- Reset mid-flight: 3 requests in flight, assert reset 1 cycle -> rsp_valid=0 the next cycle, no stale responses, coefficients read back as 0 (basic test then returns C-only results of 0).
